// File: rtl/timer_pkg.sv
// Shared constants and types for the 8051-style timer_unit: SFR map, counter modes, TCON/TMOD layout.
`timescale 1ns/1ps
package timer_pkg;

    localparam logic [2:0] ADDR_TL0  = 3'd0;
    localparam logic [2:0] ADDR_TL1  = 3'd1;
    localparam logic [2:0] ADDR_TH0  = 3'd2;
    localparam logic [2:0] ADDR_TH1  = 3'd3;
    localparam logic [2:0] ADDR_TMOD = 3'd4;
    localparam logic [2:0] ADDR_TCON = 3'd5;

    typedef enum logic [1:0] {
        MODE_13BIT      = 2'd0,
        MODE_16BIT      = 2'd1,
        MODE_AUTORELOAD = 2'd2,
        MODE_SPLIT      = 2'd3
    } mode_e;

    localparam int TCON_TF1 = 7;
    localparam int TCON_TR1 = 6;
    localparam int TCON_TF0 = 5;
    localparam int TCON_TR0 = 4;

    typedef struct packed {
        logic  gate;
        logic  ct;
        mode_e mode;
    } tmod_half_t;

    typedef struct packed {
        tmod_half_t t1;
        tmod_half_t t0;
    } tmod_t;

endpackage

// File: rtl/timer_unit_if.sv
// SFR register port between the CPU core (master) and timer_unit (slave).
`timescale 1ns/1ps
interface timer_unit_if;
    logic [2:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;

    modport master (output addr, output wr_en, output wr_data, output rd_en, input rd_data);
    modport slave  (input addr, input wr_en, input wr_data, input rd_en, output rd_data);
endinterface

// File: rtl/timer_chan.sv
// One TLx/THx counter pair with mode 0/1/2 arithmetic; split mode built only with TIMER_MODE3_EN.
// Latency: count/overflow registered on the increment clk. No backpressure: SFR writes win over increments.
`timescale 1ns/1ps
module timer_chan
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       inc_hi_i,
    input  mode_e      mode_i,
    input  logic       wr_tl_i,
    input  logic       wr_th_i,
    input  logic [7:0] wr_data_i,
    output logic [7:0] tl_o,
    output logic [7:0] th_o,
    output logic       ovf_o,
    output logic       ovf_hi_o
);

    logic [7:0]  tl_q, tl_d, th_q, th_d;
    logic [5:0]  lo13;
    logic [16:0] sum16;
    logic        inc_full;

    always_comb begin
        tl_d     = tl_q;
        th_d     = th_q;
        ovf_o    = 1'b0;
        ovf_hi_o = 1'b0;
        inc_full = inc_i & ~wr_tl_i & ~wr_th_i;
        lo13     = {1'b0, tl_q[4:0]} + 6'd1;
        sum16    = {1'b0, th_q, tl_q} + 17'd1;
        case (mode_i)
            MODE_13BIT: begin
                if (inc_full) begin
                    tl_d = {tl_q[7:5], lo13[4:0]};
                    if (lo13[5]) begin
                        th_d  = th_q + 8'd1;
                        ovf_o = (th_q == 8'hFF);
                    end
                end
            end
            MODE_16BIT: begin
                if (inc_full) begin
                    {th_d, tl_d} = sum16[15:0];
                    ovf_o        = sum16[16];
                end
            end
            MODE_AUTORELOAD: begin
                if (inc_full) begin
                    if (tl_q == 8'hFF) begin
                        tl_d  = th_q;
                        ovf_o = 1'b1;
                    end else begin
                        tl_d = tl_q + 8'd1;
                    end
                end
            end
            default: begin
`ifdef TIMER_MODE3_EN
                // Split halves are independent, so a write only kills its own half's increment.
                if (inc_i && !wr_tl_i) begin
                    tl_d  = tl_q + 8'd1;
                    ovf_o = (tl_q == 8'hFF);
                end
                if (inc_hi_i && !wr_th_i) begin
                    th_d     = th_q + 8'd1;
                    ovf_hi_o = (th_q == 8'hFF);
                end
`endif
            end
        endcase
        if (wr_tl_i) tl_d = wr_data_i;
        if (wr_th_i) th_d = wr_data_i;
    end

`ifndef TIMER_MODE3_EN
    logic unused_inc_hi;
    assign unused_inc_hi = inc_hi_i;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            tl_q <= 8'h00;
            th_q <= 8'h00;
        end else begin
            tl_q <= tl_d;
            th_q <= th_d;
        end
    end

    assign tl_o = tl_q;
    assign th_o = th_q;

endmodule

// File: rtl/timer_unit.sv
// Two 8051 timer/counters with prescaler, T-pin sync, TCON/TMOD SFRs; mode 3 split under TIMER_MODE3_EN.
// Latency: rd_data one clk after rd_en; timing one clk after the overflow tick.
// No backpressure: every SFR access completes in a single clk.
`timescale 1ns/1ps
module timer_unit
    import timer_pkg::*;
#(
    parameter int PRESCALE = 12
) (
    input  logic         clk,
    input  logic         reset,
    timer_unit_if.slave  bus,
    input  logic [1:0]   int_n,
    input  logic [1:0]   t_pin,
    input  logic [1:0]   intr_ack,
    output logic [1:0]   timing
);

    logic [7:0] pre_q, pre_d;
    logic       tick;
    logic [1:0] t_meta_q, t_sync_q, t_prev_q, t_prev_d;
    tmod_t      tmod_q, tmod_d;
    logic [1:0] tr_q, tr_d, tf_q, tf_d;
    logic [1:0] timing_q;
    logic [7:0] rd_data_q, rd_data_d, rd_mux, tcon_val;
    logic       wr_tl0, wr_tl1, wr_th0, wr_th1, wr_tmod, wr_tcon;
    logic [1:0] fall, run, inc;
    logic       inc0_hi, split0;
    logic [7:0] tl0, th0, tl1, th1;
    logic       ovf0, ovf1, ovf0_hi, unused_ovf1_hi;
    logic [1:0] tf_set, tf_clr;

    assign tick     = (pre_q == 8'(PRESCALE - 1));
    assign pre_d    = tick ? 8'd0 : pre_q + 8'd1;
    // Falling edge seen between the previous tick's sample and this tick's sample.
    assign fall     = t_prev_q & ~t_sync_q;
    assign t_prev_d = tick ? t_sync_q : t_prev_q;

    assign wr_tl0  = bus.wr_en && (bus.addr == ADDR_TL0);
    assign wr_tl1  = bus.wr_en && (bus.addr == ADDR_TL1);
    assign wr_th0  = bus.wr_en && (bus.addr == ADDR_TH0);
    assign wr_th1  = bus.wr_en && (bus.addr == ADDR_TH1);
    assign wr_tmod = bus.wr_en && (bus.addr == ADDR_TMOD);
    assign wr_tcon = bus.wr_en && (bus.addr == ADDR_TCON);

    assign run[0] = tr_q[0] & (~tmod_q.t0.gate | int_n[0]);
    assign run[1] = tr_q[1] & (~tmod_q.t1.gate | int_n[1]);
    assign inc[0] = tick & run[0] & (~tmod_q.t0.ct | fall[0]);

`ifdef TIMER_MODE3_EN
    // TH0 borrows TR1 and TF1 while timer 0 is split; timer 1 in mode 3 simply stops.
    assign split0  = (tmod_q.t0.mode == MODE_SPLIT);
    assign inc0_hi = tick & tr_q[1];
    assign inc[1]  = tick & run[1] & (~tmod_q.t1.ct | fall[1]) & (tmod_q.t1.mode != MODE_SPLIT);
`else
    assign split0  = 1'b0;
    assign inc0_hi = 1'b0;
    assign inc[1]  = tick & run[1] & (~tmod_q.t1.ct | fall[1]);
`endif

    timer_chan u_chan0 (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (inc[0]),
        .inc_hi_i  (inc0_hi),
        .mode_i    (tmod_q.t0.mode),
        .wr_tl_i   (wr_tl0),
        .wr_th_i   (wr_th0),
        .wr_data_i (bus.wr_data),
        .tl_o      (tl0),
        .th_o      (th0),
        .ovf_o     (ovf0),
        .ovf_hi_o  (ovf0_hi)
    );

    timer_chan u_chan1 (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (inc[1]),
        .inc_hi_i  (1'b0),
        .mode_i    (tmod_q.t1.mode),
        .wr_tl_i   (wr_tl1),
        .wr_th_i   (wr_th1),
        .wr_data_i (bus.wr_data),
        .tl_o      (tl1),
        .th_o      (th1),
        .ovf_o     (ovf1),
        .ovf_hi_o  (unused_ovf1_hi)
    );

    // Set beats clear so an overflow coinciding with an acknowledge is never lost.
    assign tf_set = {split0 ? ovf0_hi : ovf1, ovf0};
    assign tf_clr = intr_ack | {2{wr_tcon}};
    assign tf_d   = tf_set | (tf_q & ~tf_clr);
    assign tr_d   = wr_tcon ? {bus.wr_data[TCON_TR1], bus.wr_data[TCON_TR0]} : tr_q;
    assign tmod_d = wr_tmod ? tmod_t'(bus.wr_data) : tmod_q;

    always_comb begin
        tcon_val           = 8'h00;
        tcon_val[TCON_TF1] = tf_q[1];
        tcon_val[TCON_TR1] = tr_q[1];
        tcon_val[TCON_TF0] = tf_q[0];
        tcon_val[TCON_TR0] = tr_q[0];
        rd_mux = 8'h00;
        case (bus.addr)
            ADDR_TL0:  rd_mux = tl0;
            ADDR_TL1:  rd_mux = tl1;
            ADDR_TH0:  rd_mux = th0;
            ADDR_TH1:  rd_mux = th1;
            ADDR_TMOD: rd_mux = tmod_q;
            ADDR_TCON: rd_mux = tcon_val;
            default:   rd_mux = 8'h00;
        endcase
        rd_data_d = bus.rd_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= 8'd0;
            t_meta_q  <= 2'b00;
            t_sync_q  <= 2'b00;
            t_prev_q  <= 2'b00;
            tmod_q    <= '0;
            tr_q      <= 2'b00;
            tf_q      <= 2'b00;
            timing_q  <= 2'b00;
            rd_data_q <= 8'h00;
        end else begin
            pre_q     <= pre_d;
            t_meta_q  <= t_pin;
            t_sync_q  <= t_meta_q;
            t_prev_q  <= t_prev_d;
            tmod_q    <= tmod_d;
            tr_q      <= tr_d;
            tf_q      <= tf_d;
            timing_q  <= tf_q;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign timing      = timing_q;

endmodule

// File: tb/tb_timer_unit.sv
// Bench for timer_unit: directed scenarios plus random SFR traffic against a per-clk reference model.
`timescale 1ns/1ps
module tb_timer_unit;
    import timer_pkg::*;

    localparam int PRESCALE = 12;
`ifdef TIMER_MODE3_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] int_n, t_pin, intr_ack, timing;

    timer_unit_if bus ();

    timer_unit #(.PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .int_n    (int_n),
        .t_pin    (t_pin),
        .intr_ack (intr_ack),
        .timing   (timing)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counters held as plain integers, advanced by the mode arithmetic.
    int         m_pc;
    bit [1:0]   m_s1, m_s2, m_prev;
    int         m_tl [2];
    int         m_th [2];
    bit [7:0]   m_tmod;
    bit [1:0]   m_tr, m_tf, m_timing;
    bit [7:0]   m_rd;

    function automatic bit [7:0] reg_val(input logic [2:0] a);
        case (a)
            3'd0: return 8'(m_tl[0]);
            3'd1: return 8'(m_tl[1]);
            3'd2: return 8'(m_th[0]);
            3'd3: return 8'(m_th[1]);
            3'd4: return m_tmod;
            3'd5: return {m_tf[1], m_tr[1], m_tf[0], m_tr[0], 4'b0000};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        bit       tick, run, inc, wl, wh, ovf_hi, split0, wcon;
        bit [1:0] fall, ovf, md, set, clr;
        int       v;
        if (reset) begin
            m_pc = 0; m_s1 = 0; m_s2 = 0; m_prev = 0;
            m_tl = '{0, 0}; m_th = '{0, 0};
            m_tmod = 0; m_tr = 0; m_tf = 0; m_timing = 0; m_rd = 0;
            return;
        end
        tick = (m_pc == PRESCALE - 1);
        if (bus.rd_en) m_rd = reg_val(bus.addr);
        m_timing = m_tf;
        fall = tick ? (m_prev & ~m_s2) : 2'b00;
        if (tick) m_prev = m_s2;
        m_s2 = m_s1;
        m_s1 = t_pin;
        m_pc = tick ? 0 : m_pc + 1;
        ovf = 2'b00;
        ovf_hi = 1'b0;
        split0 = SPLIT_EN && (m_tmod[1:0] == 2'd3);
        for (int x = 0; x < 2; x++) begin
            md  = m_tmod[4*x +: 2];
            run = m_tr[x] && (!m_tmod[4*x+3] || int_n[x]);
            inc = tick && run && (!m_tmod[4*x+2] || fall[x]);
            wl  = bus.wr_en && (bus.addr == 3'(x));
            wh  = bus.wr_en && (bus.addr == 3'(x + 2));
            if (md == 2'd3) begin
                if (x == 0 && SPLIT_EN) begin
                    if (inc && !wl) begin
                        ovf[0] = (m_tl[0] == 255);
                        m_tl[0] = (m_tl[0] + 1) % 256;
                    end
                    if (tick && m_tr[1] && !wh) begin
                        ovf_hi = (m_th[0] == 255);
                        m_th[0] = (m_th[0] + 1) % 256;
                    end
                end
            end else if (inc && !wl && !wh) begin
                case (md)
                    2'd0: begin
                        v = m_th[x] * 32 + m_tl[x] % 32 + 1;
                        ovf[x] = (v == 8192);
                        v = v % 8192;
                        m_tl[x] = (m_tl[x] / 32) * 32 + v % 32;
                        m_th[x] = v / 32;
                    end
                    2'd1: begin
                        v = m_th[x] * 256 + m_tl[x] + 1;
                        ovf[x] = (v == 65536);
                        v = v % 65536;
                        m_th[x] = v / 256;
                        m_tl[x] = v % 256;
                    end
                    default: begin
                        if (m_tl[x] == 255) begin
                            m_tl[x] = m_th[x];
                            ovf[x] = 1'b1;
                        end else begin
                            m_tl[x] = m_tl[x] + 1;
                        end
                    end
                endcase
            end
            if (wl) m_tl[x] = int'(bus.wr_data);
            if (wh) m_th[x] = int'(bus.wr_data);
        end
        wcon = bus.wr_en && (bus.addr == ADDR_TCON);
        set  = {split0 ? ovf_hi : ovf[1], ovf[0]};
        clr  = intr_ack | {2{wcon}};
        m_tf = set | (m_tf & ~clr);
        if (wcon) m_tr = {bus.wr_data[6], bus.wr_data[4]};
        if (bus.wr_en && bus.addr == ADDR_TMOD) m_tmod = bus.wr_data;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("timing", timing, m_timing);
        check("rd_data", bus.rd_data, m_rd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.addr = a; bus.wr_data = d; bus.wr_en = 1'b1;
        cycle();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [2:0] a, input logic [7:0] exp);
        bus.addr = a; bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        check(tag, bus.rd_data, exp);
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            if (m_pc == PRESCALE - 1) seen++;
            cycle();
        end
    endtask

    task automatic align_tick();
        while (m_pc != PRESCALE - 1) cycle();
    endtask

    task automatic pin0_falls(input int n);
        t_pin[0] = 1'b1;
        run_ticks(2);
        for (int i = 0; i < n; i++) begin
            t_pin[0] = 1'b0;
            run_ticks(2);
            t_pin[0] = 1'b1;
            run_ticks(2);
        end
    endtask

    initial begin
        reset = 1'b1; int_n = 2'b11; t_pin = 2'b00; intr_ack = 2'b00;
        bus.addr = 3'd0; bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_en = 1'b0;

        // Reset state
        do_reset();
        for (int a = 0; a < 8; a++) rd_expect("reset_reg", 3'(a), 8'h00);

        // Mode 1 16-bit overflow, timing lag and acknowledge
        do_reset();
        wr(ADDR_TMOD, 8'h01); wr(ADDR_TH0, 8'hFF); wr(ADDR_TL0, 8'hFE); wr(ADDR_TCON, 8'h10);
        run_ticks(2);
        check("m1_timing_lag", timing, 2'b00);
        cycle();
        check("m1_timing", timing, 2'b01);
        rd_expect("m1_tl0", ADDR_TL0, 8'h00);
        rd_expect("m1_th0", ADDR_TH0, 8'h00);
        rd_expect("m1_tcon", ADDR_TCON, 8'h30);
        intr_ack = 2'b01; cycle(); intr_ack = 2'b00; cycle();
        check("m1_ack_timing", timing, 2'b00);
        rd_expect("m1_ack_tcon", ADDR_TCON, 8'h10);

        // Mode 2 autoreload
        do_reset();
        wr(ADDR_TMOD, 8'h20); wr(ADDR_TH1, 8'hF0); wr(ADDR_TL1, 8'hFF); wr(ADDR_TCON, 8'h40);
        run_ticks(1);
        rd_expect("m2_reload", ADDR_TL1, 8'hF0);
        check("m2_timing", timing, 2'b10);
        intr_ack = 2'b10; cycle(); intr_ack = 2'b00;
        run_ticks(15);
        rd_expect("m2_tl1_ff", ADDR_TL1, 8'hFF);
        rd_expect("m2_tcon_clr", ADDR_TCON, 8'h40);
        run_ticks(1);
        rd_expect("m2_reload2", ADDR_TL1, 8'hF0);
        rd_expect("m2_th1", ADDR_TH1, 8'hF0);
        rd_expect("m2_tcon_tf", ADDR_TCON, 8'hC0);

        // Mode 0 13-bit, TL[7:5] preserved
        do_reset();
        wr(ADDR_TMOD, 8'h00); wr(ADDR_TL0, 8'hFF); wr(ADDR_TH0, 8'hFF); wr(ADDR_TCON, 8'h10);
        run_ticks(1);
        rd_expect("m0_tl0", ADDR_TL0, 8'hE0);
        rd_expect("m0_th0", ADDR_TH0, 8'h00);
        rd_expect("m0_tcon", ADDR_TCON, 8'h30);

        // Gated counter mode
        do_reset();
        t_pin = 2'b11; int_n = 2'b10;
        wr(ADDR_TMOD, 8'h0D); wr(ADDR_TL0, 8'h00); wr(ADDR_TH0, 8'h00); wr(ADDR_TCON, 8'h10);
        pin0_falls(3);
        rd_expect("gate_blocked", ADDR_TL0, 8'h00);
        int_n = 2'b11;
        pin0_falls(3);
        rd_expect("gate_open", ADDR_TL0, 8'h03);

        // Write vs increment, overflow vs acknowledge
        do_reset();
        wr(ADDR_TMOD, 8'h01); wr(ADDR_TL0, 8'h10); wr(ADDR_TCON, 8'h10);
        align_tick();
        wr(ADDR_TL0, 8'h55);
        rd_expect("col_wr_wins", ADDR_TL0, 8'h55);
        wr(ADDR_TH0, 8'hFF); wr(ADDR_TL0, 8'hFF);
        align_tick();
        intr_ack = 2'b01; cycle(); intr_ack = 2'b00;
        rd_expect("col_ovf_wins", ADDR_TCON, 8'h30);

        // Mode 3 split (or hold when split is not built)
        do_reset();
        wr(ADDR_TMOD, 8'h03); wr(ADDR_TL0, 8'hFF); wr(ADDR_TH0, 8'hFF); wr(ADDR_TCON, 8'h50);
        run_ticks(1);
        cycle();
        check("m3_timing", timing, SPLIT_EN ? 2'b11 : 2'b00);
        rd_expect("m3_tl0", ADDR_TL0, SPLIT_EN ? 8'h00 : 8'hFF);
        rd_expect("m3_th0", ADDR_TH0, SPLIT_EN ? 8'h00 : 8'hFF);

        // Random SFR traffic checked every clk against the model
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            reset       = ($urandom_range(0, 999) == 0);
            bus.wr_en   = ($urandom_range(0, 99) < 8);
            bus.rd_en   = ($urandom_range(0, 3) == 0);
            bus.addr    = 3'($urandom_range(0, 7));
            bus.wr_data = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            intr_ack    = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 31) == 0) int_n = 2'($urandom);
            if ($urandom_range(0, 7) == 0)  t_pin = 2'($urandom);
            cycle();
        end
        reset = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; intr_ack = 2'b00;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
- Two 8051-style timer/counters (T0, T1) sitting directly upstream of the CPU core.
- They drive its `timing[1:0]` interrupt-request inputs.
- Software-visible SFRs: TL0, TL1, TH0, TH1, TMOD, TCON. The core reaches them through a simple register port.
- Timing comes from the 12 MHz oscillator through an internal machine-cycle prescaler.

Parameters:
- PRESCALE, 12, oscillator clocks per machine cycle (count tick); legal range 2..255.

Ports:
- clk  in  1  oscillator clock, 12 MHz.
- reset  in  1  synchronous, active-high reset.
- addr  in  3  SFR select: 0 TL0, 1 TL1, 2 TH0, 3 TH1, 4 TMOD, 5 TCON, 6-7 unused.
- wr_en  in  1  write strobe, one clk wide.
- wr_data  in  8  write data.
- rd_en  in  1  read strobe.
- rd_data  out  8  registered read data.
- int_n  in  2  external INT1/INT0 levels, used for gating, active-low.
- t_pin  in  2  external T1/T0 count inputs, asynchronous.
- intr_ack  in  2  core vector acknowledge, one clk pulse; clears TF1/TF0.
- timing  out  2  {TF1, TF0} interrupt requests to the core.

Behaviour:
- **Reset:** all SFRs, prescaler, synchronizers, `rd_data` and `timing` = 0.
- **Prescaler:** counts 0..PRESCALE-1; `tick` is asserted when count == PRESCALE-1. First tick comes on the PRESCALE-th clk after reset deasserts. Reset mid-count restarts it at 0.
- **t_pin synchronizer:** two-flop per bit. Counter mode (C/T=1) increments on a tick when the synchronized sample taken at this tick is 0 and the sample from the previous tick was 1. Timer mode (C/T=0) increments on every tick.
- **Run enable:** run_x = TRx & (~GATEx | int_n[x]).
- **TMOD layout:** [7] GATE1, [6] C/T1, [5:4] M1, [3] GATE0, [2] C/T0, [1:0] M0.
- **TCON layout:** [7] TF1, [6] TR1, [5] TF0, [4] TR0. Bits [3:0] read 0, writes ignored.
- **Mode 0:** 13-bit. TL[4:0] counts; TL[7:5] hold. A carry out of TL[4:0]=1F increments TH. TH FF->00 with carry sets TF.
- **Mode 1:** 16-bit TH:TL. FFFF->0000 sets TF.
- **Mode 2:** TL counts. On TL=FF overflow, TL<=TH and TF set; TH is unchanged.
- **Mode 3, timer 0 (split):**
  - TL0 is an 8-bit counter using TR0/GATE0/C/T0; its overflow sets TF0.
  - TH0 is an 8-bit timer counting ticks when TR1=1; its overflow sets TF1.
  - Timer 1 keeps counting in its own mode but never sets TF1.
- **Mode 3, timer 1:** holds its count.
- **TF clearing:** TFx is cleared by `intr_ack[x]` or by a TCON write.
- **`timing`:** registered copy of {TF1, TF0}. It rises on the clk after the overflow tick.
- **Read:** `rd_en` in cycle n gives `rd_data` valid in n+1; it holds until the next `rd_en`. Unused addresses read 00.
- **Collision priority, same clk:**
  - Write to TLx/THx vs increment: the write wins and that increment is lost.
  - Overflow vs `intr_ack` or TCON write clearing TF: the overflow wins (TF=1).
  - TCON write of TR takes effect from the next tick.
- Writes to unused addresses are ignored.

Optional Feature:
- Macro: TIMER_MODE3_EN.
- Defined: mode 3 behaves as specified above.
- Undefined: M=3 on either timer makes that timer hold its count and never set TF. TH0 gets no extra coupling to TR1/TF1. Split logic is not synthesized.

Decomposition:
- Package timer_pkg holds:
  - SFR address constants ADDR_TL0..ADDR_TCON.
  - Mode encodings MODE_13BIT=0, MODE_16BIT=1, MODE_AUTORELOAD=2, MODE_SPLIT=3.
  - TCON bit-index constants.
- Sub-module timer_chan is instantiated twice.
  - It takes the inc enable, mode, and TL/TH write ports.
  - It outputs TL, TH and an overflow pulse.
- The top level owns the prescaler, synchronizers, TF/TCON logic, mode-3 cross-coupling and the read mux.

Test Plan:
- Mode 1 with PRESCALE=12: TMOD=01, TH0=FF, TL0=FE, TR0=1. After 2 ticks (24 clk) TL0:TH0=0000, TF0=1, `timing`=01 one clk later. `intr_ack`=01 clears it.
- Mode 2 autoreload: TMOD=20, TH1=F0, TL1=FF, TR1=1. On the first tick TL1<=F0 and TF1=1. Ticks 2..16 count TL1 F1..FF; the 17th tick overflows again.
- Mode 0 13-bit: TL0=1F, TH0=FF. The next tick gives TL0[4:0]=00, TH0=00, TF0=1, with TL0[7:5] preserved (e.g. TL0=E0 from E0|1F=FF start).
- Gate/counter: TMOD=0D (GATE0=1, C/T0=1, M0=1), TR0=1, `int_n[0]`=0 with 3 t_pin falls gives no count. With `int_n[0]`=1 and 3 falls spaced ≥2 ticks apart, TL0 advances by 3.
- Collisions: wr_en TL0=55 in the tick clk gives TL0=55. Overflow coinciding with `intr_ack`[0] leaves TF0=1.
- Mode 3 (TIMER_MODE3_EN): TMOD=03, TR0=1, TR1=1, TL0=FF, TH0=FF. After one tick TF0=1, TF1=1, `timing`=11. Without the macro, counts are unchanged and `timing`=00.
